// File: rtl/multiplier_seq64.sv
// multiplier_seq64 -- sequential unsigned shift-add multiplier.
//
// Multiplies multiplicand by multiplier and presents the full 2*WIDTH-bit
// product on {result_h, result_l}. op_done and ovf hold while the product
// is valid. op_clear aborts any state back to IDLE.
//
// Build option: define RADIX4_EN to retire two multiplier bits per clock,
// which halves EXEC to WIDTH/2 edges. Leave it undefined for the radix-2
// datapath with WIDTH edges. Ports, reset values and results are the same
// in both builds.
module multiplier_seq64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_start,
  input  logic             op_clear,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] result_l,
  output logic [WIDTH-1:0] result_h,
  output logic             op_busy,
  output logic             op_done,
  output logic             ovf
);

`ifdef RADIX4_EN
  localparam int ITERS = WIDTH / 2;
  localparam int SUM_W = WIDTH + 2;
`else
  localparam int ITERS = WIDTH;
  localparam int SUM_W = WIDTH + 1;
`endif

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;    // latched multiplicand
  logic [WIDTH-1:0] acc_hi;   // upper product half
  logic [WIDTH-1:0] acc_lo;   // shifts out multiplier bits, shifts in product bits
  logic [CW-1:0]    cnt;      // iterations completed

  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
`ifdef RADIX4_EN
  logic [SUM_W-1:0] partial;
`endif

  // One shift-add iteration computed from the current accumulator.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    sum     = '0;
    step_hi = acc_hi;
    step_lo = acc_lo;
`ifdef RADIX4_EN
    partial = '0;
    unique case (acc_lo[1:0])
      2'd0: partial = '0;
      2'd1: partial = {2'b00, a_reg};
      2'd2: partial = {1'b0, a_reg, 1'b0};
      2'd3: partial = {1'b0, a_reg, 1'b0} + {2'b00, a_reg};
      default: partial = '0;
    endcase
    // The widest sum is 4*(2^WIDTH-1), which fits in WIDTH+2 bits.
    sum     = {2'b00, acc_hi} + partial;
    step_hi = sum[WIDTH+1:2];
    step_lo = {sum[1:0], acc_lo[WIDTH-1:2]};
`else
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_reg} : {SUM_W{1'b0}});
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], acc_lo[WIDTH-1:1]};
`endif
  end

  // Control FSM and datapath registers. Priority: reset > op_clear > op_start > iterate.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: all state here uses non-blocking assignments, so every register samples values from before this edge.
    if (!reset_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      op_busy <= 1'b0;
      op_done <= 1'b0;
      ovf     <= 1'b0;
    end else if (op_clear) begin
      state   <= IDLE;
      a_reg   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      op_busy <= 1'b0;
      op_done <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (op_start) begin
            state   <= EXEC;
            a_reg   <= multiplicand;
            acc_hi  <= '0;
            acc_lo  <= multiplier;
            cnt     <= '0;
            op_busy <= 1'b1;
            op_done <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        EXEC: begin
          // op_start is ignored here: no restart, no operand recapture.
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state   <= DONE;
            op_busy <= 1'b0;
            op_done <= 1'b1;
            ovf     <= |step_hi;
          end
        end
        default: begin
          state   <= IDLE;
          op_busy <= 1'b0;
          op_done <= 1'b0;
          ovf     <= 1'b0;
        end
      endcase
    end
  end

  // The accumulator registers are the product outputs. They read zero in IDLE.
  assign result_l = acc_lo;
  assign result_h = acc_hi;

endmodule
